// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86 unified-memory arbiter: state encoding,
// default RAM address width and the byte-lane masks for 32-bit stores.
package y86_mem_pkg;

  localparam int AW_DEFAULT = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_F_A  = 3'd1;
  localparam logic [2:0] ST_F_B  = 3'd2;
  localparam logic [2:0] ST_F_C  = 3'd3;
  localparam logic [2:0] ST_M_RD = 3'd4;
  localparam logic [2:0] ST_M_WR = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    F_A  = ST_F_A,
    F_B  = ST_F_B,
    F_C  = ST_F_C,
    M_RD = ST_M_RD,
    M_WR = ST_M_WR
  } state_e;

  // Byte 0 of a RAM word is mask bit 7 / data bits [63:56].
  localparam logic [7:0] MASK_UPPER = 8'hF0;
  localparam logic [7:0] MASK_LOWER = 8'h0F;

endpackage

// File: rtl/y86_fetch_align.sv
// Combinational instruction-window extractor: treats {lo, hi} as 16
// consecutive big-endian bytes and returns the 6 bytes starting at byte off.
// When the window fits in one word, hi is a don't-care.
module y86_fetch_align
  import y86_mem_pkg::*;
(
  input  logic [63:0] lo,
  input  logic [63:0] hi,
  input  logic [2:0]  off,
  output logic [47:0] inst
);

  logic [127:0] cat_shifted;

  // Shift the selected byte to the top, then take the top 48 bits.
  always_comb begin
    cat_shifted = {lo, hi} << {off, 3'b000};
    inst        = cat_shifted[127:80];
  end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Single-port RAM arbiter/sequencer shared by the fetch and memory stages.
//
// Handshake: a requester raises *_req (level) with its command fields and
// holds it until the matching *_done pulse. Commands are sampled only on the
// accepting edge in IDLE. *_done is a one-cycle pulse; the requester drops
// *_req during that cycle or it is accepted again. Data requests win over
// fetch; an accepted transaction always runs to completion (except reset).
module y86_mem_arbiter
  import y86_mem_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_pc,
  output logic [47:0]   f_inst,
  output logic          f_done,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [31:0]   m_addr,
  input  logic [31:0]   m_wdata,
  output logic [31:0]   m_rdata,
  output logic          m_done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wmask,
  output logic [63:0]   ram_wdata,
  input  logic [63:0]   ram_rdata,
  output logic [2:0]    dbg_state
);

  state_e          state_q, state_d;
  logic            phase_q, phase_d;     // M_RD: 0 = addr cycle, 1 = data arriving
  logic [2:0]      off_q, off_d;         // fetch byte offset within the word
  logic [63:0]     lo_q, lo_d;           // first word of a split fetch
  logic            m_sel_q, m_sel_d;     // load from lower half (m_addr[2])
  logic [47:0]     f_inst_q, f_inst_d;
  logic            f_done_q, f_done_d;
  logic [31:0]     m_rdata_q, m_rdata_d;
  logic            m_done_q, m_done_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic            ram_we_q, ram_we_d;
  logic [7:0]      ram_wmask_q, ram_wmask_d;
  logic [63:0]     ram_wdata_q, ram_wdata_d;

  logic            split;
  logic [63:0]     align_lo;
  logic [47:0]     align_inst;
  logic            unused_bits;

  // Offsets 3..7 push the 6-byte window past the end of the first word.
  assign split    = (off_q >= 3'd3);
  assign align_lo = split ? lo_q : ram_rdata;

  y86_fetch_align u_align (
    .lo   (align_lo),
    .hi   (ram_rdata),
    .off  (off_q),
    .inst (align_inst)
  );

  assign unused_bits = ^{f_pc[31:AW+3], m_addr[31:AW+3], m_addr[1:0]};

  // Next-state and registered-output logic; done and write-enable default low.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    off_d       = off_q;
    lo_d        = lo_q;
    m_sel_d     = m_sel_q;
    f_inst_d    = f_inst_q;
    f_done_d    = 1'b0;
    m_rdata_d   = m_rdata_q;
    m_done_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wmask_d = ram_wmask_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          ram_addr_d = m_addr[AW+2:3];
          m_sel_d    = m_addr[2];
          if (m_we) begin
            ram_wdata_d = {m_wdata, m_wdata};
            ram_wmask_d = m_addr[2] ? MASK_LOWER : MASK_UPPER;
            ram_we_d    = 1'b1;
            state_d     = M_WR;
          end else begin
            phase_d = 1'b0;
            state_d = M_RD;
          end
        end else if (f_req) begin
          ram_addr_d = f_pc[AW+2:3];
          off_d      = f_pc[2:0];
          state_d    = F_A;
        end
      end
      F_A: begin
        if (split) begin
          ram_addr_d = ram_addr_q + AW'(1);  // wraps to word 0 naturally
          state_d    = F_B;
        end else begin
          state_d = F_C;
        end
      end
      F_B: begin
        lo_d    = ram_rdata;
        state_d = F_C;
      end
      F_C: begin
        f_inst_d = align_inst;
        f_done_d = 1'b1;
        state_d  = IDLE;
      end
      M_RD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          m_rdata_d = m_sel_q ? ram_rdata[31:0] : ram_rdata[63:32];
          m_done_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      M_WR: begin
        m_done_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      off_q       <= '0;
      lo_q        <= '0;
      m_sel_q     <= 1'b0;
      f_inst_q    <= '0;
      f_done_q    <= 1'b0;
      m_rdata_q   <= '0;
      m_done_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wmask_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      off_q       <= off_d;
      lo_q        <= lo_d;
      m_sel_q     <= m_sel_d;
      f_inst_q    <= f_inst_d;
      f_done_q    <= f_done_d;
      m_rdata_q   <= m_rdata_d;
      m_done_q    <= m_done_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wmask_q <= ram_wmask_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign f_inst    = f_inst_q;
  assign f_done    = f_done_q;
  assign m_rdata   = m_rdata_q;
  assign m_done    = m_done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wmask = ram_wmask_q;
  assign ram_wdata = ram_wdata_q;
  assign dbg_state = state_q;

endmodule
